// File: rtl/layer_seq_ctrl_if.sv
// Handshake bundle between layer_seq_ctrl and its environment: the network
// controller (start/abort), the 3-bit phase counter (cnt, cnt_set, cnt_reset)
// and the FP MAC datapath (mac_done, acc_clr, mac_en, in_addr, neuron_idx,
// out_we), plus the layer status outputs (busy, done, err).
//   master : environment side, drives start/abort/cnt/mac_done
//   slave  : sequencer side, drives every other signal
interface layer_seq_ctrl_if #(
  parameter int unsigned IDX_W = 4
);
  logic             start;
  logic             abort;
  logic [2:0]       cnt;
  logic             mac_done;
  logic             cnt_set;
  logic             cnt_reset;
  logic             acc_clr;
  logic             mac_en;
  logic [2:0]       in_addr;
  logic [IDX_W-1:0] neuron_idx;
  logic             out_we;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, cnt, mac_done,
    input  cnt_set, cnt_reset, acc_clr, mac_en, in_addr, neuron_idx,
           out_we, busy, done, err
  );

  modport slave (
    input  start, abort, cnt, mac_done,
    output cnt_set, cnt_reset, acc_clr, mac_en, in_addr, neuron_idx,
           out_we, busy, done, err
  );
endinterface

// File: rtl/layer_seq_ctrl.sv
// Per-layer sequencer. For each of N_NEURON neurons it pulses the phase
// counter's set input, lets the counter run 1..7 to produce 7 MAC product
// enables with in_addr 0..6, waits (with a watchdog) for the FP MAC result,
// then strobes out_we. A layer ends with a one-cycle done pulse.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - layer_seq_ctrl_if.slave (start/abort/cnt/mac_done in;
//           cnt_set/cnt_reset/acc_clr/mac_en/in_addr/neuron_idx/out_we/
//           busy/done/err out)
module layer_seq_ctrl #(
  parameter int unsigned N_NEURON = 4,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input logic             clk,
  input logic             reset,
  layer_seq_ctrl_if.slave bus
);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]       state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [WD_W-1:0]  wd, wd_d;
  logic             err, err_d;
  logic             first_run, first_run_d;
  logic             set_q, set_d;
  logic             clr_q, clr_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic             crst_q, crst_d;
  logic             run_active;

  // Pulse registers are loaded on the transition into their state, so each
  // pulse is high for exactly the cycle spent in SET / WRITE / FIN, or the
  // first IDLE cycle after an abort or fault (cnt_reset).
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    err_d       = err;
    first_run_d = 1'b0;
    set_d       = 1'b0;
    clr_d       = 1'b0;
    we_d        = 1'b0;
    done_d      = 1'b0;
    crst_d      = 1'b0;
    if (bus.abort) begin
      if (state != S_IDLE) begin
        state_d = S_IDLE;
        crst_d  = 1'b1;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            err_d   = 1'b0;
            idx_d   = '0;
            state_d = S_SET;
            set_d   = 1'b1;
            clr_d   = 1'b1;
          end
        end
        S_SET: begin
          state_d     = S_RUN;
          first_run_d = 1'b1;
        end
        S_RUN: begin
          // cnt==0 is only legal in the first RUN cycle (counter latency).
          if (bus.cnt == 3'd7) begin
            state_d = S_WAIT;
          end else if (bus.cnt == 3'd0 && !first_run) begin
            err_d   = 1'b1;
            crst_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          // mac_done is tested first so it wins over a watchdog expiry.
          if (bus.mac_done) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            crst_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_WRITE: begin
          if (idx == IDX_W'(N_NEURON - 1)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx + IDX_W'(1);
            state_d = S_SET;
            set_d   = 1'b1;
            clr_d   = 1'b1;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    // Watchdog counts only while staying in WAIT; zero on entry.
    wd_d = (state == S_WAIT && state_d == S_WAIT) ? wd + WD_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      wd        <= '0;
      err       <= 1'b0;
      first_run <= 1'b0;
      set_q     <= 1'b0;
      clr_q     <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      crst_q    <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      wd        <= wd_d;
      err       <= err_d;
      first_run <= first_run_d;
      set_q     <= set_d;
      clr_q     <= clr_d;
      we_q      <= we_d;
      done_q    <= done_d;
      crst_q    <= crst_d;
    end
  end

  assign run_active     = (state == S_RUN) && (bus.cnt != 3'd0);
  assign bus.mac_en     = run_active;
  assign bus.in_addr    = run_active ? (bus.cnt - 3'd1) : 3'd0;
  assign bus.cnt_set    = set_q;
  assign bus.acc_clr    = clr_q;
  assign bus.out_we     = we_q;
  assign bus.done       = done_q;
  assign bus.cnt_reset  = crst_q;
  assign bus.neuron_idx = idx;
  assign bus.busy       = (state != S_IDLE);
  assign bus.err        = err;
endmodule

// File: tb/tb_layer_seq_ctrl.sv
module tb_layer_seq_ctrl;
  localparam int N_NEURON = 4;
  localparam int EV_SET  = 0;
  localparam int EV_MAC  = 1;
  localparam int EV_WE   = 2;
  localparam int EV_DONE = 3;
  localparam int EV_CRST = 4;

  typedef struct packed {
    logic [3:0]  kind;
    logic [7:0]  val;
    logic [31:0] cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  logic [2:0] cnt_m;
  logic       cnt_fault = 1'b0;
  logic       auto_en = 1'b1;
  logic       mac_done_auto;
  logic       mac_stray = 1'b0;
  int         cd;

  ev_t exp_q[$];
  ev_t act_q[$];
  ev_t e, a;

  layer_seq_ctrl_if #(.IDX_W(4)) ifc ();

  layer_seq_ctrl #(.N_NEURON(N_NEURON), .IDX_W(4), .TIMEOUT(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Phase counter model: set loads 1, then counts up to 7, wraps to 0 and holds.
  always @(posedge clk or negedge reset) begin
    if (!reset)                cnt_m <= 3'd0;
    else if (ifc.cnt_reset)    cnt_m <= 3'd0;
    else if (ifc.cnt_set)      cnt_m <= 3'd1;
    else if (cnt_m != 3'd0)    cnt_m <= cnt_m + 3'd1;
  end
  assign ifc.cnt = cnt_fault ? 3'd0 : cnt_m;

  // MAC model: result valid in the 3rd WAIT cycle after the last product.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      cd <= 0;
      mac_done_auto <= 1'b0;
    end else begin
      mac_done_auto <= (cd == 1);
      if (auto_en && ifc.mac_en && ifc.in_addr == 3'd6) cd <= 3;
      else if (cd > 0) cd <= cd - 1;
    end
  end
  assign ifc.mac_done = mac_done_auto | mac_stray;

  function automatic ev_t mk(int k, int v, int c);
    ev_t r;
    r.kind = 4'(k);
    r.val  = 8'(v);
    r.cyc  = 32'(c);
    return r;
  endfunction

  always @(negedge clk) begin
    if (ifc.cnt_set)   act_q.push_back(mk(EV_SET, int'(ifc.acc_clr), cyc));
    if (ifc.mac_en)    act_q.push_back(mk(EV_MAC, int'(ifc.in_addr), cyc));
    if (ifc.out_we)    act_q.push_back(mk(EV_WE, int'(ifc.neuron_idx), cyc));
    if (ifc.done)      act_q.push_back(mk(EV_DONE, 0, cyc));
    if (ifc.cnt_reset) act_q.push_back(mk(EV_CRST, 0, cyc));
  end

  // Expected events for one neuron whose SET is in cycle s and WAIT lasts L.
  function automatic int push_neuron(int n, int s, int L);
    exp_q.push_back(mk(EV_SET, 1, s));
    for (int k = 0; k < 7; k++) exp_q.push_back(mk(EV_MAC, k, s + 1 + k));
    exp_q.push_back(mk(EV_WE, n, s + 8 + L));
    return s + 9 + L;
  endfunction

  task automatic do_start(output int sc);
    @(posedge clk); #1;
    ifc.start = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    reset = 1'b0;
    idle(3);
    total++;
    if ({ifc.busy, ifc.done, ifc.out_we, ifc.cnt_set, ifc.acc_clr, ifc.cnt_reset, ifc.mac_en} !== 7'b0)
      $display("FAIL reset_flags got=%b exp=0000000",
               {ifc.busy, ifc.done, ifc.out_we, ifc.cnt_set, ifc.acc_clr, ifc.cnt_reset, ifc.mac_en});
    else passed++;
    total++;
    if (ifc.neuron_idx !== 4'd0) $display("FAIL reset_idx got=%0d exp=0", ifc.neuron_idx); else passed++;
    total++;
    if (ifc.in_addr !== 3'd0) $display("FAIL reset_in_addr got=%0d exp=0", ifc.in_addr); else passed++;
    total++;
    if (ifc.err !== 1'b0) $display("FAIL reset_err got=%b exp=0", ifc.err); else passed++;
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_layer;
    int sc, s;
    exp_q.delete(); act_q.delete();
    do_start(sc);
    s = sc + 1;
    for (int n = 0; n < N_NEURON; n++) s = push_neuron(n, s, 3);
    exp_q.push_back(mk(EV_DONE, 0, s));
    for (int i = 0; i < 200 && !ifc.done; i++) @(negedge clk);
    idle(3);
    total++;
    if (ifc.busy !== 1'b0) $display("FAIL layer_busy_end got=%b exp=0", ifc.busy); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (act_q.size() == 0) $display("FAIL layer_ev got=none exp=k%0d v%0d c%0d", e.kind, e.val, e.cyc);
      else begin
        a = act_q.pop_front();
        if (a !== e) $display("FAIL layer_ev got=k%0d v%0d c%0d exp=k%0d v%0d c%0d",
                              a.kind, a.val, a.cyc, e.kind, e.val, e.cyc);
        else passed++;
      end
    end
    total++;
    if (act_q.size() != 0) $display("FAIL layer_extra got=%0d exp=0", act_q.size()); else passed++;
  endtask

  task automatic test_abort;
    int sc, s;
    bit found = 0;
    exp_q.delete(); act_q.delete();
    do_start(sc);
    s = sc + 1;
    s = push_neuron(0, s, 3);
    s = push_neuron(1, s, 3);
    exp_q.push_back(mk(EV_SET, 1, s));
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(EV_MAC, k, s + 1 + k));
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = ifc.mac_en && ifc.neuron_idx == 4'd2 && ifc.in_addr == 3'd3;
    end
    total++;
    if (!found) $display("FAIL abort_reach got=0 exp=1"); else passed++;
    ifc.abort = 1'b1;
    exp_q.push_back(mk(EV_CRST, 0, cyc + 1));
    @(posedge clk); #1;
    ifc.abort = 1'b0;
    @(negedge clk);
    total++;
    if (ifc.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", ifc.busy); else passed++;
    total++;
    if (ifc.cnt_reset !== 1'b1) $display("FAIL abort_crst got=%b exp=1", ifc.cnt_reset); else passed++;
    @(negedge clk);
    total++;
    if (ifc.cnt_reset !== 1'b0) $display("FAIL abort_crst_len got=%b exp=0", ifc.cnt_reset); else passed++;
    // Abort together with start in IDLE: start must be dropped, no pulse.
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.abort = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.abort = 1'b0;
    @(negedge clk);
    total++;
    if (ifc.busy !== 1'b0) $display("FAIL abort_beats_start got=%b exp=0", ifc.busy); else passed++;
    idle(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (act_q.size() == 0) $display("FAIL abort_ev got=none exp=k%0d v%0d c%0d", e.kind, e.val, e.cyc);
      else begin
        a = act_q.pop_front();
        if (a !== e) $display("FAIL abort_ev got=k%0d v%0d c%0d exp=k%0d v%0d c%0d",
                              a.kind, a.val, a.cyc, e.kind, e.val, e.cyc);
        else passed++;
      end
    end
    total++;
    if (act_q.size() != 0) $display("FAIL abort_extra got=%0d exp=0", act_q.size()); else passed++;
  endtask

  task automatic test_ignored;
    int sc, s;
    bit found = 0;
    exp_q.delete(); act_q.delete();
    do_start(sc);
    s = sc + 1;
    for (int n = 0; n < N_NEURON; n++) s = push_neuron(n, s, 3);
    exp_q.push_back(mk(EV_DONE, 0, s));
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = ifc.mac_en && ifc.neuron_idx == 4'd1 && ifc.in_addr == 3'd2;
    end
    ifc.start = 1'b1;
    mac_stray = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    mac_stray = 1'b0;
    for (int i = 0; i < 200 && !ifc.done; i++) @(negedge clk);
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (act_q.size() == 0) $display("FAIL ignored_ev got=none exp=k%0d v%0d c%0d", e.kind, e.val, e.cyc);
      else begin
        a = act_q.pop_front();
        if (a !== e) $display("FAIL ignored_ev got=k%0d v%0d c%0d exp=k%0d v%0d c%0d",
                              a.kind, a.val, a.cyc, e.kind, e.val, e.cyc);
        else passed++;
      end
    end
    total++;
    if (act_q.size() != 0) $display("FAIL ignored_extra got=%0d exp=0", act_q.size()); else passed++;
  endtask

  task automatic test_timeout;
    int sc, s;
    exp_q.delete(); act_q.delete();
    auto_en = 1'b0;
    do_start(sc);
    s = sc + 1;
    exp_q.push_back(mk(EV_SET, 1, s));
    for (int k = 0; k < 7; k++) exp_q.push_back(mk(EV_MAC, k, s + 1 + k));
    exp_q.push_back(mk(EV_CRST, 0, s + 72));
    for (int i = 0; i < 300 && cyc < s + 71; i++) @(negedge clk);
    total++;
    if ({ifc.busy, ifc.err} !== 2'b10) $display("FAIL tmo_last_wait got=%b exp=10", {ifc.busy, ifc.err}); else passed++;
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.err, ifc.cnt_reset} !== 3'b011)
      $display("FAIL tmo_expire got=%b exp=011", {ifc.busy, ifc.err, ifc.cnt_reset});
    else passed++;
    idle(5);
    total++;
    if (ifc.err !== 1'b1) $display("FAIL tmo_err_sticky got=%b exp=1", ifc.err); else passed++;
    auto_en = 1'b1;
    // Accepted start clears err; abort it during SET.
    do_start(sc);
    exp_q.push_back(mk(EV_SET, 1, sc + 1));
    exp_q.push_back(mk(EV_CRST, 0, sc + 2));
    @(negedge clk);
    total++;
    if ({ifc.err, ifc.cnt_set} !== 2'b01) $display("FAIL tmo_err_clear got=%b exp=01", {ifc.err, ifc.cnt_set}); else passed++;
    ifc.abort = 1'b1;
    @(posedge clk); #1;
    ifc.abort = 1'b0;
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (act_q.size() == 0) $display("FAIL tmo_ev got=none exp=k%0d v%0d c%0d", e.kind, e.val, e.cyc);
      else begin
        a = act_q.pop_front();
        if (a !== e) $display("FAIL tmo_ev got=k%0d v%0d c%0d exp=k%0d v%0d c%0d",
                              a.kind, a.val, a.cyc, e.kind, e.val, e.cyc);
        else passed++;
      end
    end
    total++;
    if (act_q.size() != 0) $display("FAIL tmo_extra got=%0d exp=0", act_q.size()); else passed++;
  endtask

  task automatic test_wd_boundary;
    int sc, s;
    exp_q.delete(); act_q.delete();
    auto_en = 1'b0;
    do_start(sc);
    s = sc + 1;
    s = push_neuron(0, s, 64);
    for (int n = 1; n < N_NEURON; n++) s = push_neuron(n, s, 3);
    exp_q.push_back(mk(EV_DONE, 0, s));
    for (int i = 0; i < 300 && cyc < sc + 72; i++) @(negedge clk);
    mac_stray = 1'b1;
    auto_en = 1'b1;
    @(posedge clk); #1;
    mac_stray = 1'b0;
    for (int i = 0; i < 200 && !ifc.done; i++) @(negedge clk);
    idle(3);
    total++;
    if (ifc.err !== 1'b0) $display("FAIL wdb_err got=%b exp=0", ifc.err); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (act_q.size() == 0) $display("FAIL wdb_ev got=none exp=k%0d v%0d c%0d", e.kind, e.val, e.cyc);
      else begin
        a = act_q.pop_front();
        if (a !== e) $display("FAIL wdb_ev got=k%0d v%0d c%0d exp=k%0d v%0d c%0d",
                              a.kind, a.val, a.cyc, e.kind, e.val, e.cyc);
        else passed++;
      end
    end
    total++;
    if (act_q.size() != 0) $display("FAIL wdb_extra got=%0d exp=0", act_q.size()); else passed++;
  endtask

  task automatic test_cnt_fault;
    int sc, s;
    bit found = 0;
    exp_q.delete(); act_q.delete();
    do_start(sc);
    s = sc + 1;
    exp_q.push_back(mk(EV_SET, 1, s));
    exp_q.push_back(mk(EV_MAC, 0, s + 1));
    exp_q.push_back(mk(EV_MAC, 1, s + 2));
    exp_q.push_back(mk(EV_CRST, 0, s + 4));
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = ifc.mac_en && ifc.neuron_idx == 4'd0 && ifc.in_addr == 3'd1;
    end
    @(posedge clk); #1;
    cnt_fault = 1'b1;
    @(negedge clk);
    total++;
    if (ifc.mac_en !== 1'b0) $display("FAIL fault_mac_en got=%b exp=0", ifc.mac_en); else passed++;
    @(posedge clk); #1;
    cnt_fault = 1'b0;
    @(negedge clk);
    total++;
    if ({ifc.err, ifc.busy, ifc.cnt_reset} !== 3'b101)
      $display("FAIL fault_result got=%b exp=101", {ifc.err, ifc.busy, ifc.cnt_reset});
    else passed++;
    idle(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (act_q.size() == 0) $display("FAIL fault_ev got=none exp=k%0d v%0d c%0d", e.kind, e.val, e.cyc);
      else begin
        a = act_q.pop_front();
        if (a !== e) $display("FAIL fault_ev got=k%0d v%0d c%0d exp=k%0d v%0d c%0d",
                              a.kind, a.val, a.cyc, e.kind, e.val, e.cyc);
        else passed++;
      end
    end
    total++;
    if (act_q.size() != 0) $display("FAIL fault_extra got=%0d exp=0", act_q.size()); else passed++;
  endtask

  task automatic test_async_reset;
    int sc, s;
    bit found = 0;
    do_start(sc);
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = ifc.mac_en && ifc.neuron_idx == 4'd1 && ifc.in_addr == 3'd6;
    end
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    total++;
    if ({ifc.busy, ifc.done, ifc.out_we, ifc.cnt_set, ifc.acc_clr, ifc.cnt_reset, ifc.mac_en, ifc.err} !== 8'b0)
      $display("FAIL areset_flags got=%b exp=00000000",
               {ifc.busy, ifc.done, ifc.out_we, ifc.cnt_set, ifc.acc_clr, ifc.cnt_reset, ifc.mac_en, ifc.err});
    else passed++;
    total++;
    if (ifc.neuron_idx !== 4'd0) $display("FAIL areset_idx got=%0d exp=0", ifc.neuron_idx); else passed++;
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    exp_q.delete(); act_q.delete();
    do_start(sc);
    s = sc + 1;
    for (int n = 0; n < N_NEURON; n++) s = push_neuron(n, s, 3);
    exp_q.push_back(mk(EV_DONE, 0, s));
    for (int i = 0; i < 200 && !ifc.done; i++) @(negedge clk);
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (act_q.size() == 0) $display("FAIL areset_ev got=none exp=k%0d v%0d c%0d", e.kind, e.val, e.cyc);
      else begin
        a = act_q.pop_front();
        if (a !== e) $display("FAIL areset_ev got=k%0d v%0d c%0d exp=k%0d v%0d c%0d",
                              a.kind, a.val, a.cyc, e.kind, e.val, e.cyc);
        else passed++;
      end
    end
    total++;
    if (act_q.size() != 0) $display("FAIL areset_extra got=%0d exp=0", act_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_layer();
    test_abort();
    test_ignored();
    test_timeout();
    test_wd_boundary();
    test_cnt_fault();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/layer_seq_ctrl.md
Name: layer_seq_ctrl

Overview:
- Per-layer sequencer that drives the 3-bit phase counter (set/reset inputs, cnt output running 1..7 then 0).
- Consumes the counter's cnt to generate input/weight addresses and MAC enables for 7 products per neuron.
- Handles the floating-point MAC completion handshake and emits an output-write strobe per neuron.
- Sits between the network top-level controller (start/abort) and the phase counter plus FP MAC datapath.

Parameters:
- N_NEURON, 4, neurons per layer; legal range 1..16.
- IDX_W, 4, width of neuron_idx; must satisfy 2^IDX_W >= N_NEURON.
- TIMEOUT, 64, maximum cycles to wait in WAIT for mac_done before error.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to process a layer; ignored unless state is IDLE.
- abort  in  1  synchronous abort; valid in any state.
- cnt  in  3  phase count from the counter.
- mac_done  in  1  one-cycle pulse: FP MAC result for the current neuron is valid.
- cnt_set  out  1  one-cycle pulse to the counter's set input.
- cnt_reset  out  1  one-cycle pulse to the counter's reset input.
- acc_clr  out  1  one-cycle pulse clearing the MAC accumulator.
- mac_en  out  1  MAC product enable.
- in_addr  out  3  input/weight index within the current neuron (0..6).
- neuron_idx  out  IDX_W  current neuron index.
- out_we  out  1  one-cycle write strobe for the neuron result at neuron_idx.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the layer completes.
- err  out  1  sticky timeout flag; cleared only by reset or by an accepted start.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, neuron_idx=0, watchdog=0, err=0.
  - All pulse outputs 0; mac_en=0; in_addr=0.
- States: IDLE, SET, RUN, WAIT, WRITE, FIN. State is registered.
  - cnt_set, acc_clr, out_we, done and cnt_reset are registered one-cycle pulses, aligned with the state named below.
- IDLE:
  - On start=1 and abort=0: clear err, neuron_idx=0, go to SET.
- SET (1 cycle):
  - cnt_set=1 and acc_clr=1; go to RUN.
  - The counter shows cnt=1 in the first RUN cycle.
- RUN:
  - mac_en=(cnt!=0); in_addr=cnt-1 when cnt!=0, else 0. Both are combinational from cnt and state.
  - When cnt==7, go to WAIT. That gives exactly 7 mac_en cycles per neuron, with in_addr 0..6.
  - If cnt==0 in any RUN cycle other than the first: set err=1, pulse cnt_reset, go to IDLE.
- WAIT:
  - watchdog increments every cycle.
  - mac_done=1: go to WRITE and clear the watchdog.
  - watchdog==TIMEOUT-1 without mac_done: set err=1, pulse cnt_reset, go to IDLE.
  - If mac_done arrives in the same cycle the watchdog hits its limit, mac_done wins.
- WRITE (1 cycle):
  - out_we=1 with the current neuron_idx.
  - If neuron_idx==N_NEURON-1, go to FIN.
  - Otherwise increment neuron_idx and go to SET.
- FIN (1 cycle):
  - done=1; go to IDLE. neuron_idx holds its last value until the next start.
- Abort:
  - In any non-IDLE state: next cycle state=IDLE, cnt_reset=1 for one cycle, no out_we, no done, err unchanged.
  - Abort beats every other transition, including start in IDLE.
- Ignored inputs:
  - mac_done outside WAIT.
  - start while busy.
- Layer latency with a MAC latency of L cycles after the last product:
  - per neuron = 1 (SET) + 7 (RUN) + L (WAIT) + 1 (WRITE);
  - plus 1 cycle for FIN.
- Reset asserted mid-layer: immediate return to IDLE with all outputs 0. No cnt_reset pulse is required; the counter is reset by the system reset.

Test Plan:
- Reset, then start with N_NEURON=4 and mac_done 3 cycles after entering WAIT:
  - each neuron shows cnt_set+acc_clr, then 7 mac_en cycles with in_addr 0..6, then out_we with neuron_idx 0,1,2,3;
  - done pulses once, 12 cycles after the last out_we's SET started;
  - total 48 cycles from SET to FIN.
- Abort asserted during RUN at cnt=4 of neuron 2:
  - next cycle state IDLE, busy=0, cnt_reset=1 for exactly 1 cycle, no out_we for neuron 2, no done.
- mac_done withheld in WAIT (TIMEOUT=64):
  - after 64 cycles err=1, cnt_reset pulses, busy=0;
  - err stays 1 until the next accepted start clears it.
- Start pulsed during RUN and mac_done pulsed during RUN:
  - no effect on sequence; count of out_we pulses unchanged.
- Counter fault (force cnt=0 at the 3rd RUN cycle):
  - err=1, cnt_reset pulse, return to IDLE.
- Async reset dropped mid-WAIT:
  - outputs 0 within the same cycle, state IDLE, neuron_idx=0, err=0;
  - a fresh start then completes normally.
